game_state_ctrl: RTL and testbench

- Consumes the per-pixel sprite outputs of the dino and obstacle renderers, which are empty flags driven for the current scan coordinate.
- Detects a pixel-level collision and runs the game state machine (UnBegin/Running/Dead).
- Drives the 2-bit gamestate bus back to the renderers and keeps a BCD score and high score for the HUD.
- Sits between the VGA scan/render layer and the input layer.

---
 rtl/game_state_ctrl.sv | 98 +++++++++
 tb/tb_game_state_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: pixel collision detection, UnBegin/Running/Dead state machine and BCD score keeping
module game_state_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int SCORE_DIV = 6,
  parameter int DEAD_HOLD = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refreshclk,
  input  logic        jump,
  input  logic [9:0]  xx,
  input  logic [8:0]  yy,
  input  logic        isemptyDino,
  input  logic        isemptyObstacle,
  output logic [1:0]  gamestate,
  output logic [15:0] score,
  output logic [15:0] hiscore,
  output logic        hit
);
  typedef enum logic [1:0] {UNBEGIN = 2'b00, RUNNING = 2'b01, DEAD = 2'b10} state_t;
  localparam int FW = $clog2(SCORE_DIV + 1);
  localparam int HW = $clog2(DEAD_HOLD + 1);
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);
  state_t state, state_nx;
  logic [2:0] ref_sync;
  logic jump_q;
  logic [FW-1:0] fc;
  logic [HW-1:0] hold;
  logic tick, jump_rise, coll, start, die, restart, last;
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic c;
    r = s;
    c = 1'b1;
    for (int i = 0; i < 4; i++)
      if (c) begin
        if (r[4*i+:4] == 4'd9) r[4*i+:4] = 4'd0;
        else begin
          r[4*i+:4] = r[4*i+:4] + 4'd1;
          c = 1'b0;
        end
      end
    return s == 16'h9999 ? s : r;
  endfunction
  assign tick      = ref_sync[1] & ~ref_sync[2];
  assign jump_rise = jump & ~jump_q;
  assign coll      = state == RUNNING && {1'b0, xx} < H_LIM && {1'b0, yy} < V_LIM && !isemptyDino && !isemptyObstacle;
  assign start     = state == UNBEGIN && jump_rise;
  assign die       = state == RUNNING && tick && hit;
  assign restart   = state == DEAD && jump_rise && hold == HW'(DEAD_HOLD);
  assign last      = fc == FW'(SCORE_DIV - 1);
  assign gamestate = state;
  // synchronise the frame strobe and keep the jump history for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ref_sync <= '0;
      jump_q   <= 1'b1;
    end else begin
      ref_sync <= {ref_sync[1:0], refreshclk};
      jump_q   <= jump;
    end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= UNBEGIN;
    else state <= state_nx;
  // next state; the unused encoding falls back to UnBegin
  always_comb
    state_nx = start ? RUNNING : die ? DEAD : restart ? UNBEGIN :
               (state == RUNNING || state == DEAD) ? state : UNBEGIN;
  // per-frame collision latch; a hit sampled on the tick clk belongs to the next frame
  always_ff @(posedge clk or posedge rst)
    if (rst) hit <= 1'b0;
    else if (start) hit <= 1'b0;
    else if (tick) hit <= coll;
    else hit <= hit | coll;
  // frame divider, BCD score, high score and dead-hold counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fc      <= '0;
      score   <= '0;
      hiscore <= '0;
      hold    <= '0;
    end else begin
      if (start) begin
        score <= '0;
        fc    <= '0;
      end else if (state == RUNNING && tick && !hit) begin
        fc <= last ? '0 : fc + FW'(1);
        if (last) score <= bcd_inc(score);
      end
      if (die) begin
        hold <= '0;
        if (score > hiscore) hiscore <= score;
      end else if (state == DEAD && tick && hold != HW'(DEAD_HOLD)) hold <= hold + HW'(1);
    end
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed table-driven and sequence checks for game_state_ctrl
module tb_game_state_ctrl;
  logic clk = 1'b0, rst = 1'b1, refreshclk = 1'b0, jump = 1'b1;
  logic [9:0] xx = '0;
  logic [8:0] yy = '0;
  logic isemptyDino = 1'b1, isemptyObstacle = 1'b1;
  logic [1:0] gamestate, f_gamestate;
  logic [15:0] score, hiscore, f_score, f_hiscore;
  logic hit, f_hit;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic       run;
    logic [9:0] x;
    logic [8:0] y;
    logic       d;
    logic       o;
    logic       ehit;
    logic [1:0] egs;
  } vec_t;
  vec_t vt[9];
  always #5 clk = ~clk;
  game_state_ctrl dut (
    .clk(clk), .rst(rst), .refreshclk(refreshclk), .jump(jump), .xx(xx), .yy(yy),
    .isemptyDino(isemptyDino), .isemptyObstacle(isemptyObstacle),
    .gamestate(gamestate), .score(score), .hiscore(hiscore), .hit(hit)
  );
  game_state_ctrl #(.SCORE_DIV(1)) u_fast (
    .clk(clk), .rst(rst), .refreshclk(refreshclk), .jump(jump), .xx(xx), .yy(yy),
    .isemptyDino(isemptyDino), .isemptyObstacle(isemptyObstacle),
    .gamestate(f_gamestate), .score(f_score), .hiscore(f_hiscore), .hit(f_hit)
  );
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_tick(input int n);
    repeat (n) begin
      refreshclk = 1'b1;
      step(2);
      refreshclk = 1'b0;
      step(2);
    end
  endtask
  task automatic jump_pulse;
    jump = 1'b1;
    step(1);
    jump = 1'b0;
    step(1);
  endtask
  task automatic overlap(input logic [9:0] x, input logic [8:0] y, input logic d, input logic o);
    xx = x;
    yy = y;
    isemptyDino = d;
    isemptyObstacle = o;
    step(1);
    isemptyDino = 1'b1;
    isemptyObstacle = 1'b1;
    xx = '0;
    yy = '0;
  endtask
  initial begin
    vt[0] = '{1'b1, 10'd300, 9'd200, 1'b0, 1'b0, 1'b1, 2'b10};
    vt[1] = '{1'b1, 10'd700, 9'd200, 1'b0, 1'b0, 1'b0, 2'b01};
    vt[2] = '{1'b1, 10'd300, 9'd490, 1'b0, 1'b0, 1'b0, 2'b01};
    vt[3] = '{1'b1, 10'd300, 9'd200, 1'b1, 1'b0, 1'b0, 2'b01};
    vt[4] = '{1'b1, 10'd300, 9'd200, 1'b0, 1'b1, 1'b0, 2'b01};
    vt[5] = '{1'b0, 10'd300, 9'd200, 1'b0, 1'b0, 1'b0, 2'b00};
    vt[6] = '{1'b1, 10'd639, 9'd479, 1'b0, 1'b0, 1'b1, 2'b10};
    vt[7] = '{1'b1, 10'd640, 9'd479, 1'b0, 1'b0, 1'b0, 2'b01};
    vt[8] = '{1'b1, 10'd639, 9'd480, 1'b0, 1'b0, 1'b0, 2'b01};
    step(2);
    rst = 1'b0;
    step(3);
    chk("reset_gs_jump_held", gamestate, 16'h0);
    chk("reset_score", score, 16'h0);
    chk("reset_hiscore", hiscore, 16'h0);
    chk("reset_hit", hit, 16'h0);
    jump = 1'b0;
    step(2);
    jump_pulse;
    chk("start_gs", gamestate, 16'h1);
    chk("start_score", score, 16'h0);
    do_tick(60);
    chk("score_60_ticks", score, 16'h0010);
    chk("fast_score_60_ticks", f_score, 16'h0060);
    jump_pulse;
    chk("running_ignores_jump", gamestate, 16'h1);
    do_tick(120);
    chk("score_180_ticks", score, 16'h0030);
    overlap(10'd300, 9'd200, 1'b0, 1'b0);
    chk("hit_set", hit, 16'h1);
    chk("hit_waits_tick", gamestate, 16'h1);
    do_tick(1);
    chk("dead_after_tick", gamestate, 16'h2);
    chk("hiscore_first", hiscore, 16'h0030);
    chk("hit_cleared_on_tick", hit, 16'h0);
    do_tick(10);
    jump_pulse;
    chk("early_jump_ignored", gamestate, 16'h2);
    do_tick(20);
    chk("score_frozen_dead", score, 16'h0030);
    jump_pulse;
    chk("dead_to_unbegin", gamestate, 16'h0);
    jump_pulse;
    chk("restart_gs", gamestate, 16'h1);
    chk("restart_score", score, 16'h0);
    chk("restart_hiscore_kept", hiscore, 16'h0030);
    do_tick(252);
    chk("score_42", score, 16'h0042);
    overlap(10'd300, 9'd200, 1'b0, 1'b0);
    do_tick(1);
    chk("second_dead", gamestate, 16'h2);
    chk("hiscore_update", hiscore, 16'h0042);
    do_tick(30);
    jump_pulse;
    jump_pulse;
    do_tick(6);
    chk("midgame_score", score, 16'h0001);
    overlap(10'd300, 9'd200, 1'b0, 1'b0);
    chk("midgame_hit", hit, 16'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_gs", gamestate, 16'h0);
    chk("async_rst_score", score, 16'h0);
    chk("async_rst_hiscore", hiscore, 16'h0);
    chk("async_rst_hit", hit, 16'h0);
    step(1);
    rst = 1'b0;
    step(1);
    for (int i = 0; i < 9; i++) begin
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
      if (vt[i].run) jump_pulse;
      overlap(vt[i].x, vt[i].y, vt[i].d, vt[i].o);
      chk($sformatf("vec%0d_hit", i), hit, 16'(vt[i].ehit));
      do_tick(1);
      chk($sformatf("vec%0d_gs", i), gamestate, 16'(vt[i].egs));
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    jump_pulse;
    do_tick(999);
    chk("fast_0999", f_score, 16'h0999);
    do_tick(1);
    chk("fast_bcd_carry_1000", f_score, 16'h1000);
    chk("score_1000_ticks", score, 16'h0166);
    do_tick(8999);
    chk("fast_9999", f_score, 16'h9999);
    do_tick(12);
    chk("fast_saturate", f_score, 16'h9999);
    chk("fast_still_running", f_gamestate, 16'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
